// File: rtl/saturating_narrower.sv
// Two-stage signed width reducer: optional round-half-up arithmetic shift, then
// saturation to a narrower signed width, with valid/ready on both sides and clip statistics.
module saturating_narrower #(
    parameter int WIDTH_OF_INPUT_DATA  = 16,
    parameter int WIDTH_OF_OUTPUT_DATA = 8,
    parameter int SHIFT_AMOUNT         = 0,
    parameter int COUNTER_WIDTH        = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            input_valid,
    output logic                            input_ready,
    input  logic [WIDTH_OF_INPUT_DATA-1:0]  input_data,
    output logic                            output_valid,
    input  logic                            output_ready,
    output logic [WIDTH_OF_OUTPUT_DATA-1:0] output_data,
    output logic                            saturated,
    output logic                            overflow_sticky,
    output logic [COUNTER_WIDTH-1:0]        saturation_count,
    input  logic                            clear_statistics
);
    localparam int WI = WIDTH_OF_INPUT_DATA;
    localparam int WO = WIDTH_OF_OUTPUT_DATA;

    // Saturation bounds expressed at the S1 working width (one guard bit above the input).
    localparam logic signed [WI:0] SAT_MAX = {{(WI + 2 - WO){1'b0}}, {(WO - 1){1'b1}}};
    localparam logic signed [WI:0] SAT_MIN = {{(WI + 2 - WO){1'b1}}, {(WO - 1){1'b0}}};
    localparam logic [WO-1:0] OUT_MAX = {1'b0, {(WO - 1){1'b1}}};
    localparam logic [WO-1:0] OUT_MIN = {1'b1, {(WO - 1){1'b0}}};
    localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = {COUNTER_WIDTH{1'b1}};
    localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE = {{(COUNTER_WIDTH - 1){1'b0}}, 1'b1};

    logic                   s1_valid_reg;
    logic signed [WI:0]     s1_value_reg;
    logic                   output_valid_reg;
    logic [WO-1:0]          output_data_reg;
    logic                   saturated_reg;
    logic                   overflow_sticky_reg;
    logic [COUNTER_WIDTH-1:0] saturation_count_reg;

    logic                   s1_free;
    logic                   s2_free;
    logic signed [WI:0]     extended;
    logic signed [WI:0]     rounded;
    logic                   clip_high;
    logic                   clip_low;
    logic [WO-1:0]          sat_data;

    assign s2_free     = !output_valid_reg || output_ready;
    assign s1_free     = !s1_valid_reg || s2_free;
    assign input_ready = s1_free;

    assign extended = {input_data[WI-1], input_data};

    generate
        if (SHIFT_AMOUNT == 0) begin : g_pass
            assign rounded = extended;
        end else begin : g_round
            localparam logic [WI:0] HALF = {{WI{1'b0}}, 1'b1} << (SHIFT_AMOUNT - 1);
            logic signed [WI:0] biased;
            // The guard bit keeps the half-LSB bias from wrapping at the positive extreme.
            assign biased  = extended + $signed(HALF);
            assign rounded = biased >>> SHIFT_AMOUNT;
        end
    endgenerate

    always_comb begin
        clip_high = s1_value_reg > SAT_MAX;
        clip_low  = s1_value_reg < SAT_MIN;
        sat_data  = s1_value_reg[WO-1:0];
        if (clip_high) begin
            sat_data = OUT_MAX;
        end else if (clip_low) begin
            sat_data = OUT_MIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg         <= 1'b0;
            s1_value_reg         <= '0;
            output_valid_reg     <= 1'b0;
            output_data_reg      <= '0;
            saturated_reg        <= 1'b0;
            overflow_sticky_reg  <= 1'b0;
            saturation_count_reg <= '0;
        end else begin
            if (s1_free) begin
                s1_valid_reg <= input_valid;
                if (input_valid) begin
                    s1_value_reg <= rounded;
                end
            end

            // Output holds while stalled; a bubble from S1 drops output_valid on this edge.
            if (s2_free) begin
                output_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    output_data_reg <= sat_data;
                    saturated_reg   <= clip_high || clip_low;
                end
            end

            if (clear_statistics) begin
                overflow_sticky_reg  <= 1'b0;
                saturation_count_reg <= '0;
            end else if (output_valid_reg && output_ready && saturated_reg) begin
                overflow_sticky_reg <= 1'b1;
                if (saturation_count_reg != COUNT_MAX) begin
                    saturation_count_reg <= saturation_count_reg + COUNT_ONE;
                end
            end
        end
    end

    assign output_valid     = output_valid_reg;
    assign output_data      = output_data_reg;
    assign saturated        = saturated_reg;
    assign overflow_sticky  = overflow_sticky_reg;
    assign saturation_count = saturation_count_reg;

endmodule

// File: tb/tb_saturating_narrower.sv
// Directed bench for saturating_narrower: default, shifted and narrow-counter instances
// driven by scenario tasks with hand-computed expectations.
module tb_saturating_narrower;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Instance A: defaults
    logic        a_input_valid = 1'b0, a_input_ready, a_output_valid, a_output_ready = 1'b1;
    logic [15:0] a_input_data = '0;
    logic [7:0]  a_output_data;
    logic        a_saturated, a_overflow_sticky, a_clear_statistics = 1'b0;
    logic [15:0] a_saturation_count;

    // Instance B: SHIFT_AMOUNT = 4
    logic        b_input_valid = 1'b0, b_input_ready, b_output_valid, b_output_ready = 1'b1;
    logic [15:0] b_input_data = '0;
    logic [7:0]  b_output_data;
    logic        b_saturated, b_overflow_sticky, b_clear_statistics = 1'b0;
    logic [15:0] b_saturation_count;

    // Instance C: COUNTER_WIDTH = 4
    logic        c_input_valid = 1'b0, c_input_ready, c_output_valid, c_output_ready = 1'b1;
    logic [15:0] c_input_data = '0;
    logic [7:0]  c_output_data;
    logic        c_saturated, c_overflow_sticky, c_clear_statistics = 1'b0;
    logic [3:0]  c_saturation_count;

    saturating_narrower dut_a (
        .clk(clk), .rst_n(rst_n),
        .input_valid(a_input_valid), .input_ready(a_input_ready), .input_data(a_input_data),
        .output_valid(a_output_valid), .output_ready(a_output_ready), .output_data(a_output_data),
        .saturated(a_saturated), .overflow_sticky(a_overflow_sticky),
        .saturation_count(a_saturation_count), .clear_statistics(a_clear_statistics)
    );

    saturating_narrower #(.SHIFT_AMOUNT(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .input_valid(b_input_valid), .input_ready(b_input_ready), .input_data(b_input_data),
        .output_valid(b_output_valid), .output_ready(b_output_ready), .output_data(b_output_data),
        .saturated(b_saturated), .overflow_sticky(b_overflow_sticky),
        .saturation_count(b_saturation_count), .clear_statistics(b_clear_statistics)
    );

    saturating_narrower #(.COUNTER_WIDTH(4)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .input_valid(c_input_valid), .input_ready(c_input_ready), .input_data(c_input_data),
        .output_valid(c_output_valid), .output_ready(c_output_ready), .output_data(c_output_data),
        .saturated(c_saturated), .overflow_sticky(c_overflow_sticky),
        .saturation_count(c_saturation_count), .clear_statistics(c_clear_statistics)
    );

    localparam logic [15:0] BASIC_IN  [5] = '{16'h0042, 16'h0100, 16'hFF00, 16'hFF80, 16'h007F};
    localparam logic [7:0]  BASIC_OUT [5] = '{8'h42, 8'h7F, 8'h80, 8'h80, 8'h7F};
    localparam logic        BASIC_SAT [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    localparam logic [15:0] SHIFT_IN  [8] = '{16'h0018, 16'hFFE8, 16'h7FFF, 16'h8000,
                                              16'h0008, 16'hFFF8, 16'h07F7, 16'h07F8};
    localparam logic [7:0]  SHIFT_OUT [8] = '{8'h02, 8'hFF, 8'h7F, 8'h80, 8'h01, 8'h00, 8'h7F, 8'h7F};
    localparam logic        SHIFT_SAT [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    localparam logic [15:0] BP_IN  [5] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0155};
    localparam logic [7:0]  BP_OUT [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h7F};
    localparam logic        BP_SAT [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reference for the default configuration: {saturated, output_data}
    function automatic logic [8:0] model_default(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        if (v > 127) return {1'b1, 8'h7F};
        if (v < -128) return {1'b1, 8'h80};
        return {1'b0, x[7:0]};
    endfunction

    task automatic next_period();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({a_output_valid, a_output_data, a_saturated, a_overflow_sticky, a_saturation_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_a: got valid=%b data=%h sat=%b sticky=%b count=%0d, expected all zero",
                     a_output_valid, a_output_data, a_saturated, a_overflow_sticky, a_saturation_count);
        end
        vectors++;
        if ({b_output_valid, b_output_data, b_saturated, b_overflow_sticky, b_saturation_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_b: got valid=%b data=%h sat=%b, expected all zero",
                     b_output_valid, b_output_data, b_saturated);
        end
        vectors++;
        if ({c_output_valid, c_output_data, c_saturated, c_overflow_sticky, c_saturation_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_c: got valid=%b count=%0d, expected all zero", c_output_valid, c_saturation_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_period();
    endtask

    task automatic test_basic();
        a_output_ready = 1'b1;
        for (int p = 0; p < 8; p++) begin
            a_input_valid = (p < 5);
            a_input_data  = '0;
            if (p < 5) a_input_data = BASIC_IN[p];
            @(negedge clk);
            if (p < 2 || p == 7) begin
                vectors++;
                if (a_output_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL basic_idle p=%0d: got output_valid=%b, expected 0", p, a_output_valid);
                end
            end else begin
                vectors++;
                if ({a_output_valid, a_saturated, a_output_data} !== {1'b1, BASIC_SAT[p-2], BASIC_OUT[p-2]}) begin
                    miscompares++;
                    $display("FAIL basic_out %0d: got valid=%b sat=%b data=%h, expected valid=1 sat=%b data=%h",
                             p - 2, a_output_valid, a_saturated, a_output_data, BASIC_SAT[p-2], BASIC_OUT[p-2]);
                end
            end
            next_period();
        end
        a_input_valid = 1'b0;
        vectors++;
        if (a_saturation_count !== 16'd2 || a_overflow_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_stats: got count=%0d sticky=%b, expected count=2 sticky=1",
                     a_saturation_count, a_overflow_sticky);
        end
    endtask

    task automatic test_shift();
        b_output_ready = 1'b1;
        for (int p = 0; p < 10; p++) begin
            b_input_valid = (p < 8);
            b_input_data  = '0;
            if (p < 8) b_input_data = SHIFT_IN[p];
            @(negedge clk);
            if (p >= 2) begin
                vectors++;
                if ({b_output_valid, b_saturated, b_output_data} !== {1'b1, SHIFT_SAT[p-2], SHIFT_OUT[p-2]}) begin
                    miscompares++;
                    $display("FAIL shift_out in=%h: got valid=%b sat=%b data=%h, expected valid=1 sat=%b data=%h",
                             SHIFT_IN[p-2], b_output_valid, b_saturated, b_output_data, SHIFT_SAT[p-2], SHIFT_OUT[p-2]);
                end
            end
            next_period();
        end
        b_input_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int got = 0;
        logic [7:0] held = '0;
        bit holding = 0;
        for (int p = 0; p < 60 && got < 5; p++) begin
            a_output_ready = (p >= 6);
            a_input_valid  = (idx < 5);
            a_input_data   = '0;
            if (idx < 5) a_input_data = BP_IN[idx];
            @(negedge clk);
            if (p == 5) begin
                vectors++;
                if (idx != 2 || a_input_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_accept: got accepted=%0d input_ready=%b, expected accepted=2 input_ready=0",
                             idx, a_input_ready);
                end
            end
            if (a_output_valid && !a_output_ready) begin
                if (holding) begin
                    vectors++;
                    if (a_output_data !== held) begin
                        miscompares++;
                        $display("FAIL bp_stable: got data=%h, expected held %h", a_output_data, held);
                    end
                end
                held = a_output_data;
                holding = 1;
            end else begin
                holding = 0;
            end
            if (a_output_valid && a_output_ready) begin
                vectors++;
                if ({a_saturated, a_output_data} !== {BP_SAT[got], BP_OUT[got]}) begin
                    miscompares++;
                    $display("FAIL bp_order %0d: got sat=%b data=%h, expected sat=%b data=%h",
                             got, a_saturated, a_output_data, BP_SAT[got], BP_OUT[got]);
                end
                got++;
            end
            if (a_input_valid && a_input_ready) idx++;
            next_period();
        end
        a_input_valid  = 1'b0;
        a_output_ready = 1'b1;
        vectors++;
        if (got != 5 || idx != 5) begin
            miscompares++;
            $display("FAIL bp_complete: got %0d outputs from %0d accepted, expected 5 and 5", got, idx);
        end
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            vectors++;
            if (a_output_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_duplicate: got output_valid=%b after drain, expected 0", a_output_valid);
            end
            next_period();
        end
    endtask

    task automatic test_random();
        logic [8:0] exp_q[$];
        logic [8:0] expv;
        int sent = 0;
        int got = 0;
        int clips = 0;
        int r;
        a_clear_statistics = 1'b1;
        next_period();
        a_clear_statistics = 1'b0;
        for (int p = 0; p < 20000 && got < 1000; p++) begin
            a_input_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            a_output_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                r = int'($urandom());
            end else begin
                r = int'($urandom_range(0, 400)) - 200;
            end
            a_input_data = r[15:0];
            @(negedge clk);
            if (a_output_valid && a_output_ready) begin
                expv = 9'h0;
                if (exp_q.size() > 0) expv = exp_q.pop_front();
                vectors++;
                if ({a_saturated, a_output_data} !== expv) begin
                    miscompares++;
                    $display("FAIL random %0d: got sat=%b data=%h, expected sat=%b data=%h",
                             got, a_saturated, a_output_data, expv[8], expv[7:0]);
                end
                got++;
            end
            if (a_input_valid && a_input_ready) begin
                expv = model_default(a_input_data);
                exp_q.push_back(expv);
                if (expv[8]) clips++;
                sent++;
            end
            next_period();
        end
        a_input_valid  = 1'b0;
        a_output_ready = 1'b1;
        vectors++;
        if (got != 1000) begin
            miscompares++;
            $display("FAIL random_budget: got %0d outputs, expected 1000", got);
        end
        vectors++;
        if (a_saturation_count !== 16'(clips) || a_overflow_sticky !== (clips > 0)) begin
            miscompares++;
            $display("FAIL random_stats: got count=%0d sticky=%b, expected count=%0d sticky=%b",
                     a_saturation_count, a_overflow_sticky, clips, clips > 0);
        end
    endtask

    task automatic test_counter();
        c_output_ready = 1'b1;
        for (int p = 0; p < 23; p++) begin
            c_input_valid = (p < 20);
            c_input_data  = 16'h0100;
            next_period();
        end
        c_input_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (c_saturation_count !== 4'hF || c_overflow_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL counter_hold: got count=%0d sticky=%b, expected count=15 sticky=1",
                     c_saturation_count, c_overflow_sticky);
        end
        next_period();
        c_clear_statistics = 1'b1;
        next_period();
        c_clear_statistics = 1'b0;
        // One clipped sample to get a non-zero count
        c_input_valid = 1'b1;
        next_period();
        c_input_valid = 1'b0;
        next_period();
        next_period();
        next_period();
        @(negedge clk);
        vectors++;
        if (c_saturation_count !== 4'd1) begin
            miscompares++;
            $display("FAIL counter_after_clear: got count=%0d, expected 1", c_saturation_count);
        end
        next_period();
        // Clipped transfer coincides with clear_statistics
        c_input_valid = 1'b1;
        next_period();
        c_input_valid = 1'b0;
        next_period();
        c_clear_statistics = 1'b1;
        @(negedge clk);
        vectors++;
        if (c_output_valid !== 1'b1 || c_saturated !== 1'b1) begin
            miscompares++;
            $display("FAIL counter_coincide_setup: got valid=%b sat=%b, expected 1 1", c_output_valid, c_saturated);
        end
        next_period();
        c_clear_statistics = 1'b0;
        @(negedge clk);
        vectors++;
        if (c_saturation_count !== 4'd0 || c_overflow_sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL counter_clear_wins: got count=%0d sticky=%b, expected 0 0",
                     c_saturation_count, c_overflow_sticky);
        end
        next_period();
    endtask

    task automatic test_async_reset();
        a_output_ready = 1'b1;
        a_input_data   = 16'h0100;
        a_input_valid  = 1'b1;
        next_period();
        next_period();
        a_input_valid = 1'b0;
        for (int p = 0; p < 4; p++) next_period();
        vectors++;
        if (a_overflow_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_pre: got sticky=%b, expected 1", a_overflow_sticky);
        end
        a_input_valid = 1'b1;
        a_input_data  = 16'h0033;
        next_period();
        a_input_data  = 16'h0044;
        next_period();
        a_input_valid = 1'b0;
        #2;
        vectors++;
        if (a_output_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_inflight: got output_valid=%b, expected 1", a_output_valid);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({a_output_valid, a_output_data, a_saturated, a_overflow_sticky, a_saturation_count} !== '0) begin
            miscompares++;
            $display("FAIL areset_immediate: got valid=%b data=%h sat=%b sticky=%b count=%0d, expected all zero",
                     a_output_valid, a_output_data, a_saturated, a_overflow_sticky, a_saturation_count);
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        next_period();
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            vectors++;
            if (a_output_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL areset_stale: got output_valid=%b data=%h, expected valid 0", a_output_valid, a_output_data);
            end
            next_period();
        end
        a_input_valid = 1'b1;
        a_input_data  = 16'h0055;
        next_period();
        a_input_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (a_output_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_latency_early: got output_valid=%b one cycle after accept, expected 0", a_output_valid);
        end
        next_period();
        @(negedge clk);
        vectors++;
        if (a_output_valid !== 1'b1 || a_output_data !== 8'h55) begin
            miscompares++;
            $display("FAIL areset_latency: got valid=%b data=%h, expected valid=1 data=55", a_output_valid, a_output_data);
        end
        next_period();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift();
        test_backpressure();
        test_random();
        test_counter();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/saturating_narrower.md
Name: saturating_narrower

Overview:
Pipelined signed width-reduction unit; the inverse direction of the sign-extension path. Takes a wide two's-complement sample, applies an optional rounding arithmetic right shift, then saturates it to a narrower signed width. Sits at the output of wide datapath stages (accumulators, multipliers) before narrow storage or transmit. Valid/ready handshake on both sides; saturation statistics for software/debug.

Parameters:
WIDTH_OF_INPUT_DATA, 16, wide signed input width; must be >= WIDTH_OF_OUTPUT_DATA
WIDTH_OF_OUTPUT_DATA, 8, narrow signed output width; >= 2
SHIFT_AMOUNT, 0, arithmetic right shift with round-half-up applied before saturation; 0 to WIDTH_OF_INPUT_DATA-1
COUNTER_WIDTH, 16, width of saturation event counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
input_valid  input  1  input_data is valid
input_ready  output  1  block accepts a sample this cycle
input_data  input  WIDTH_OF_INPUT_DATA  signed wide sample
output_valid  output  1  output_data is valid
output_ready  input  1  downstream accepts this cycle
output_data  output  WIDTH_OF_OUTPUT_DATA  signed narrowed sample
saturated  output  1  current output_data was clipped; qualified by output_valid
overflow_sticky  output  1  set on any transferred clipped sample; held until clear
saturation_count  output  COUNTER_WIDTH  count of transferred clipped samples
clear_statistics  input  1  synchronous clear of overflow_sticky and saturation_count

Behaviour:
- Reset: single clock domain; rst_n is asynchronous and active-low. While asserted: both stage valids 0, output_valid=0, output_data=0, saturated=0, overflow_sticky=0, saturation_count=0. Reset mid-operation discards in-flight samples; no output is produced for them after release.
- Transfer: input on input_valid && input_ready; output on output_valid && output_ready. output_data/saturated must hold stable while output_valid && !output_ready.
- Two registered stages, S1 (round/shift) and S2 (saturate, drives outputs). Latency exactly 2 cycles from input transfer to output_valid with no backpressure; throughput 1 sample/cycle.
- Flow control: s2_free = !output_valid || output_ready; s1_free = !s1_valid || s2_free; input_ready = s1_free (combinational path from output_ready allowed). S1 moves into S2 when s1_valid && s2_free. A bubble in S2 clears output_valid on the same edge. No drops, no duplicates, order preserved.
- S1 arithmetic: sign-extend input to WIDTH_OF_INPUT_DATA+1 bits; if SHIFT_AMOUNT>0 add 2^(SHIFT_AMOUNT-1), then arithmetic shift right by SHIFT_AMOUNT. SHIFT_AMOUNT=0: pass-through. Extra bit prevents overflow of the rounding add.
- S2 saturation: MAX=2^(W_OUT-1)-1, MIN=-2^(W_OUT-1). value>MAX -> MAX, saturated=1; value<MIN -> MIN, saturated=1; else low W_OUT bits, saturated=0. W_IN==W_OUT with SHIFT_AMOUNT=0: never saturates.
- Statistics: on output transfer with saturated=1, overflow_sticky<=1 and saturation_count increments, holding at all-ones (no wrap). clear_statistics wins over a simultaneous increment: both go to 0 and that event is not counted. Statistics do not affect data flow.

Test Plan:
- Defaults, output_ready=1: inputs 0x0042, 0x0100, 0xFF00, 0xFF80, 0x007F back-to-back -> outputs 0x42/0, 0x7F/1, 0x80/1, 0x80/0, 0x7F/0, each 2 cycles after its input; saturation_count=2, overflow_sticky=1.
- SHIFT_AMOUNT=4: 0x0018 (24) -> 0x02; 0xFFE8 (-24) -> 0xFF; 0x7FFF -> 0x7F, saturated=1; 0x8000 -> 0x80, saturated=1.
- Backpressure: output_ready=0 for 6 cycles while streaming 5 samples -> exactly 2 accepted, input_ready=0 thereafter; after release all 5 appear in order, output_data stable while stalled, no loss/duplicate.
- Random valid/ready toggling, 1000 samples -> output stream equals reference model sequence; count equals model clip count.
- COUNTER_WIDTH=4: 20 clipped transfers -> saturation_count=15; clear_statistics asserted on the same cycle as a clipped transfer -> count=0, sticky=0.
- Assert rst_n low asynchronously (mid-cycle) with 2 samples in flight -> output_valid and statistics 0 immediately; after release no stale samples emerge; next input emerges 2 cycles after acceptance.
